// File: rtl/flopr_pkg.sv
// Shared definitions for the flopr_pipe register chain: occupancy width helper
// and the default-width {valid, data} stage record.
package flopr_pkg;

    localparam int FLOPR_N_DEF = 64;

    typedef struct packed {
        logic                   valid;
        logic [FLOPR_N_DEF-1:0] data;
    } stage_rec_t;

    // Width needed to count 0..stages inclusive.
    function automatic int occ_w(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/flopr_stage.sv
// Single W-bit register with async active-high reset, advance enable and
// synchronous clear (clr takes priority over en).
module flopr_stage #(
    parameter int           W         = 65,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= RESET_VAL;
        else if (clr)
            q <= RESET_VAL;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/flopr_pipe.sv
// STAGES-deep chain of {valid, data} registers with global stall and per-stage flush.
// Macro FLOPR_PIPE_OCC_EN compiles in the registered valid-stage occupancy counter.
module flopr_pipe
    import flopr_pkg::*;
#(
    parameter int           N         = FLOPR_N_DEF,
    parameter int           STAGES    = 4,
    parameter logic [N-1:0] RESET_VAL = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic [STAGES-1:0]           flush,
    input  logic [N-1:0]                d,
    input  logic                        d_valid,
    output logic [N-1:0]                q,
    output logic                        q_valid,
    output logic [occ_w(STAGES)-1:0]    occupancy
);

    localparam int OW = occ_w(STAGES);

    // Bit N of each stage word is the valid flag.
    logic [N:0] stage_d [STAGES];
    logic [N:0] stage_q [STAGES];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        if (i == 0) begin : g_first
            assign stage_d[i] = {d_valid, d};
        end else begin : g_rest
            assign stage_d[i] = stage_q[i-1];
        end

        flopr_stage #(
            .W         (N + 1),
            .RESET_VAL ({1'b0, RESET_VAL})
        ) u_stage (
            .clk   (clk),
            .reset (reset),
            .en    (en),
            .clr   (flush[i]),
            .d     (stage_d[i]),
            .q     (stage_q[i])
        );
    end

    assign q       = stage_q[STAGES-1][N-1:0];
    assign q_valid = stage_q[STAGES-1][N];

`ifdef FLOPR_PIPE_OCC_EN
    logic [OW-1:0] occ_next;

    // Count valid bits as they will be after this edge, so the count stays registered.
    always_comb begin
        occ_next = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (!flush[i]) begin
                if (en)
                    occ_next = occ_next + OW'(stage_d[i][N]);
                else
                    occ_next = occ_next + OW'(stage_q[i][N]);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            occupancy <= '0;
        else
            occupancy <= occ_next;
    end
`else
    assign occupancy = '0;
`endif

endmodule

// File: tb/tb_flopr_pipe.sv
// Randomized self-checking bench for flopr_pipe (N=64, STAGES=4) against a
// behavioural array model of the chain.
module tb_flopr_pipe;

    localparam int N      = 64;
    localparam int STAGES = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic                en;
    logic [STAGES-1:0]   flush;
    logic [N-1:0]        d;
    logic                d_valid;
    logic [N-1:0]        q;
    logic                q_valid;
    logic [2:0]          occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [N-1:0] m_data [STAGES];
    logic         m_val  [STAGES];

    flopr_pipe #(.N(N), .STAGES(STAGES), .RESET_VAL('0)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .flush     (flush),
        .d         (d),
        .d_valid   (d_valid),
        .q         (q),
        .q_valid   (q_valid),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_occ();
        int c = 0;
`ifdef FLOPR_PIPE_OCC_EN
        for (int i = 0; i < STAGES; i++) c += int'(m_val[i]);
`endif
        return c;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < STAGES; i++) begin
            m_data[i] = '0;
            m_val[i]  = 1'b0;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".q"},       q,                 m_data[STAGES-1]);
        check({tag, ".q_valid"}, 64'(q_valid),      64'(m_val[STAGES-1]));
        check({tag, ".occ"},     64'(occupancy),    64'(model_occ()));
    endtask

    // Apply one set of inputs across one rising edge, advance the model, compare.
    task automatic step(input string tag, input logic e, input logic [STAGES-1:0] f,
                        input logic [N-1:0] dd, input logic dv);
        logic [N-1:0] nd [STAGES];
        logic         nv [STAGES];
        en = e; flush = f; d = dd; d_valid = dv;
        @(posedge clk);
        // Shift model: new entry at the head, oldest dropped; flush kills the arriving value.
        for (int i = 0; i < STAGES; i++) begin
            if (f[i]) begin
                nd[i] = '0; nv[i] = 1'b0;
            end else if (e) begin
                nd[i] = (i == 0) ? dd : m_data[i-1];
                nv[i] = (i == 0) ? dv : m_val[i-1];
            end else begin
                nd[i] = m_data[i]; nv[i] = m_val[i];
            end
        end
        for (int i = 0; i < STAGES; i++) begin
            m_data[i] = nd[i]; m_val[i] = nv[i];
        end
        #1;
        check_outputs(tag);
    endtask

    function automatic logic [N-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        reset = 1'b1; en = 1'b1; flush = '0; d_valid = 1'b1; d = rnd64();
        model_clear();
        // Reset held for 50 ns with random traffic applied.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            d = rnd64();
            check_outputs("reset_hold");
        end
        #2 reset = 1'b0;
        @(posedge clk); #1;   // edge with reset low loads stage 0
        m_data[0] = d; m_val[0] = 1'b1;
        check_outputs("post_reset");

        // Streaming: ten valid words back to back.
        model_clear();
        reset = 1'b1; #1; reset = 1'b0;
        for (int i = 0; i < 10; i++) step("stream", 1'b1, '0, rnd64(), 1'b1);

        // Mid-stream async reset clears outputs before the next edge.
        reset = 1'b1; #1;
        model_clear();
        check_outputs("mid_reset");
        #2 reset = 1'b0;

        // Stall: A, B, C loaded, three stall cycles, then A must arrive.
        step("stall_ld", 1'b1, '0, 64'hA, 1'b1);
        step("stall_ld", 1'b1, '0, 64'hB, 1'b1);
        step("stall_ld", 1'b1, '0, 64'hC, 1'b1);
        for (int i = 0; i < 3; i++) step("stall_hold", 1'b0, '0, rnd64(), 1'b1);
        step("stall_go", 1'b1, '0, 64'hD, 1'b1);
        check("stall_latency", q, 64'hA);

        // Flush stage 1 with the chain holding 1,2,3,4.
        for (int v = 4; v >= 1; v--) step("flush_ld", 1'b1, '0, 64'(v), 1'b1);
        step("flush_mid", 1'b1, 4'b0010, 64'h55, 1'b1);
        check("flush_q", q, 64'h3);
`ifdef FLOPR_PIPE_OCC_EN
        check("flush_occ3", 64'(occupancy), 64'd3);
`endif
        // Flush the last stage while stalled.
        step("flush_stall", 1'b0, 4'b1000, rnd64(), 1'b1);
        check("flush_stall_qv", 64'(q_valid), 64'd0);
        // Flush all with en=1 empties the chain.
        step("flush_all", 1'b1, 4'b1111, rnd64(), 1'b1);
        check("flush_all_occ", 64'(occupancy), 64'd0);

        // Random traffic with occasional stalls, flushes and resets.
        for (int i = 0; i < 400; i++) begin
            logic [STAGES-1:0] f;
            f = ($urandom_range(0, 5) == 0) ? STAGES'($urandom) : '0;
            if ($urandom_range(0, 60) == 0) begin
                reset = 1'b1; #1;
                model_clear();
                check_outputs("rand_reset");
                #1 reset = 1'b0;
            end
            step("rand", $urandom_range(0, 3) != 0, f, rnd64(), $urandom_range(0, 1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
